// File: rtl/rvga_line_fill_buffer.sv
// rvga_line_fill_buffer
//
// Fetches one cacheline from a word-wide memory and assembles it into a
// single wide register. On a request, the line base is latched and reads
// are issued word by word, either critical-word-first (wrapping around the
// line) or ascending from word 0. Reads may be pipelined; responses return
// in order and land in the slot their read addressed. The first returned
// word is also reported on a one-cycle side channel. The block holds the
// finished line until the consumer takes it.
//
// Ports
//   clk              clock, rising edge
//   rst_n            asynchronous active-low reset
//   req_v_i          fill request valid
//   req_ready_o      request can be accepted (IDLE only)
//   req_addr_i       miss byte address
//   mem_v_o          word read request valid
//   mem_ready_i      memory accepts the read
//   mem_addr_o       word-aligned read address
//   mem_resp_v_i     read data valid (in request order)
//   mem_resp_data_i  read data
//   crit_v_o         one-cycle pulse carrying the first returned word
//   crit_data_o      first returned word
//   line_v_o         assembled line valid
//   line_ready_i     consumer accepts the line
//   line_o           line, word i at [i*WORD_W +: WORD_W]
//   line_addr_o      line-aligned base address
//
// state | meaning
// IDLE  | waiting for a fill request
// FILL  | issuing reads and collecting responses
// DONE  | line complete, waiting for the consumer

module rvga_line_fill_buffer #(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter bit          CWF    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_v_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              mem_v_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_resp_v_i,
    input  logic [WORD_W-1:0] mem_resp_data_i,
    output logic              crit_v_o,
    output logic [WORD_W-1:0] crit_data_o,
    output logic              line_v_o,
    input  logic              line_ready_i,
    output logic [LINE_W-1:0] line_o,
    output logic [ADDR_W-1:0] line_addr_o
);

    localparam int unsigned WORDS  = LINE_W / WORD_W;
    localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned BYTE_W = $clog2(WORD_W / 8);
    localparam int unsigned LOFF_W = BYTE_W + IDX_W;

    localparam logic [IDX_W:0] WORDS_C = (IDX_W + 1)'(WORDS);
    localparam logic [IDX_W:0] ONE_C   = (IDX_W + 1)'(1);

    generate
        if ((LINE_W % WORD_W) != 0 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0 ||
            WORD_W < 8 || (WORD_W & (WORD_W - 1)) != 0) begin : g_bad_params
            $error("rvga_line_fill_buffer: LINE_W/WORD_W must be a power of two >= 2, WORD_W a power of two >= 8");
        end
        // Byte offset within a word never matters: reads are word-aligned.
        if (BYTE_W > 0) begin : g_byte_off
            logic unused_byte_off;
            assign unused_byte_off = ^req_addr_i[BYTE_W-1:0];
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [IDX_W-1:0]   start_q, start_d;
    logic [IDX_W:0]     iss_q, iss_d;
    logic [IDX_W:0]     rcv_q, rcv_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic               crit_v_q, crit_v_d;
    logic [WORD_W-1:0]  crit_data_q, crit_data_d;

    logic               issue;
    logic               accept;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   rcv_idx;

    // Word indices wrap naturally in IDX_W-bit arithmetic.
    assign issue_idx = start_q + iss_q[IDX_W-1:0];
    assign rcv_idx   = start_q + rcv_q[IDX_W-1:0];

    assign req_ready_o = (state_q == IDLE);
    assign mem_v_o     = (state_q == FILL) && (iss_q < WORDS_C);
    assign mem_addr_o  = base_q | (ADDR_W'(issue_idx) << BYTE_W);
    assign issue       = mem_v_o && mem_ready_i;
    // Responses beyond what was issued (stray or pre-reset) are dropped.
    assign accept      = (state_q == FILL) && mem_resp_v_i && (rcv_q < iss_q);

    assign crit_v_o    = crit_v_q;
    assign crit_data_o = crit_data_q;
    assign line_v_o    = (state_q == DONE);
    assign line_o      = line_q;
    assign line_addr_o = base_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        start_d     = start_q;
        iss_d       = iss_q;
        rcv_d       = rcv_q;
        line_d      = line_q;
        crit_v_d    = 1'b0;
        crit_data_d = crit_data_q;

        unique case (state_q)
            IDLE: begin
                if (req_v_i) begin
                    base_d  = {req_addr_i[ADDR_W-1:LOFF_W], {LOFF_W{1'b0}}};
                    start_d = CWF ? req_addr_i[LOFF_W-1:BYTE_W] : '0;
                    iss_d   = '0;
                    rcv_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (issue) begin
                    iss_d = iss_q + ONE_C;
                end
                if (accept) begin
                    for (int w = 0; w < int'(WORDS); w++) begin
                        if (rcv_idx == IDX_W'(w)) begin
                            line_d[w*WORD_W +: WORD_W] = mem_resp_data_i;
                        end
                    end
                    rcv_d = rcv_q + ONE_C;
                    if (rcv_q == '0) begin
                        crit_v_d    = 1'b1;
                        crit_data_d = mem_resp_data_i;
                    end
                end
                // Leave on the edge that captures the last word.
                if (rcv_d == WORDS_C) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (line_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            start_q     <= '0;
            iss_q       <= '0;
            rcv_q       <= '0;
            line_q      <= '0;
            crit_v_q    <= 1'b0;
            crit_data_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            start_q     <= start_d;
            iss_q       <= iss_d;
            rcv_q       <= rcv_d;
            line_q      <= line_d;
            crit_v_q    <= crit_v_d;
            crit_data_q <= crit_data_d;
        end
    end

endmodule
